// File: rtl/display_pkg.sv
// Shared constants for the debug seven-segment display path: digit code format and
// mode encodings.
package display_pkg;

   localparam int unsigned CODE_W = 5;
   localparam logic [CODE_W-1:0] BLANK_CODE = 5'h10;

   localparam logic [1:0] MODE_LIVE   = 2'b00;
   localparam logic [1:0] MODE_FREEZE = 2'b01;
   localparam logic [1:0] MODE_SCROLL = 2'b10;
   localparam logic [1:0] MODE_MANUAL = 2'b11;

   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/display_page_ctrl.sv
// Page selection for the display pager: auto-scroll prescaler, manual step edge detect
// and source-change detect driving a wrapping page counter.
module display_page_ctrl
   import display_pkg::*;
#(
   parameter int unsigned NUM_PAGES = 2,
   parameter int unsigned TICK_DIV  = 4,
   parameter int unsigned SEL_W     = 2,
   parameter int unsigned PAGE_W    = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [SEL_W-1:0]  sel_i,
   input  logic [1:0]        mode_i,
   input  logic              step_i,
   output logic [PAGE_W-1:0] page_o
);

   localparam int unsigned PRESC_W = $clog2(TICK_DIV);
   localparam logic [PAGE_W-1:0]  LAST_PAGE  = PAGE_W'(NUM_PAGES - 1);
   localparam logic [PRESC_W-1:0] LAST_COUNT = PRESC_W'(TICK_DIV - 1);

   logic [PRESC_W-1:0] presc_q, presc_d, presc_cur;
   logic [PAGE_W-1:0]  page_q, page_d, page_inc;
   logic [SEL_W-1:0]   sel_q;
   logic [1:0]         mode_q;
   logic               step_q;

   assign page_inc = (page_q == LAST_PAGE) ? '0 : page_q + 1'b1;
   // A prescaler held over from FREEZE must not shorten the first page after re-entry.
   assign presc_cur = (mode_q == MODE_SCROLL) ? presc_q : '0;

   always_comb begin
      presc_d = presc_q;
      page_d  = page_q;
      if ((sel_i != sel_q) && (mode_i != MODE_FREEZE)) begin
         presc_d = '0;
         page_d  = '0;
      end else begin
         case (mode_i)
            MODE_LIVE: begin
               presc_d = '0;
               page_d  = '0;
            end
            MODE_SCROLL: begin
               if (presc_cur == LAST_COUNT) begin
                  presc_d = '0;
                  page_d  = page_inc;
               end else begin
                  presc_d = presc_cur + 1'b1;
               end
            end
            MODE_MANUAL: begin
               presc_d = '0;
               if (step_i && !step_q) page_d = page_inc;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q <= '0;
         page_q  <= '0;
         sel_q   <= '0;
         mode_q  <= MODE_LIVE;
         step_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         page_q  <= page_d;
         sel_q   <= sel_i;
         mode_q  <= mode_i;
         step_q  <= step_i;
      end
   end

   assign page_o = page_q;

endmodule

// File: rtl/display_pager.sv
// Seven-segment front end for the debug display: selects and registers a source word,
// slices it into hex nibble codes and shows one page of NUM_DIGITS at a time.
module display_pager
   import display_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned TICK_DIV   = 25000000,
   localparam int unsigned NUM_NIB   = (DATA_WIDTH + 3) / 4,
   localparam int unsigned NUM_PAGES = (NUM_NIB + NUM_DIGITS - 1) / NUM_DIGITS,
   localparam int unsigned SEL_W     = clog2_min1(NUM_SRC),
   localparam int unsigned PAGE_W    = clog2_min1(NUM_PAGES)
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]  srcData,
   input  logic [SEL_W-1:0]               srcSel,
   input  logic [1:0]                     mode,
   input  logic                           pageStep,
   output logic [NUM_DIGITS*CODE_W-1:0]   digitCodes,
   output logic [PAGE_W-1:0]              pageIdx,
   output logic                           frozen
);

   logic [DATA_WIDTH-1:0]          src_mux, data_q;
   logic [NUM_NIB*4-1:0]           data_pad;
   logic [NUM_DIGITS*CODE_W-1:0]   codes_d;

   // Out-of-range selects fall back to source 0.
   always_comb begin
      src_mux = srcData[DATA_WIDTH-1:0];
      for (int i = 1; i < int'(NUM_SRC); i++) begin
         if (srcSel == SEL_W'(i)) src_mux = srcData[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign data_pad = (NUM_NIB*4)'(data_q);

   always_comb begin
      codes_d = '0;
      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
         codes_d[d*CODE_W +: CODE_W] = BLANK_CODE;
         for (int n = 0; n < int'(NUM_NIB); n++) begin
            if (int'(pageIdx) * int'(NUM_DIGITS) + d == n) begin
               codes_d[d*CODE_W +: CODE_W] = {1'b0, data_pad[n*4 +: 4]};
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         data_q     <= '0;
         digitCodes <= {NUM_DIGITS{BLANK_CODE}};
         frozen     <= 1'b0;
      end else begin
         if (mode != MODE_FREEZE) data_q <= src_mux;
         digitCodes <= codes_d;
         frozen     <= (mode == MODE_FREEZE);
      end
   end

   display_page_ctrl #(
      .NUM_PAGES (NUM_PAGES),
      .TICK_DIV  (TICK_DIV),
      .SEL_W     (SEL_W),
      .PAGE_W    (PAGE_W)
   ) u_page_ctrl (
      .clk_i  (Clk),
      .rst_i  (Rst),
      .sel_i  (srcSel),
      .mode_i (mode),
      .step_i (pageStep),
      .page_o (pageIdx)
   );

endmodule
